conv_result_collector: RTL and testbench
========================================

Name: conv_result_collector

Overview:
- Sits downstream of the streaming convolution block and receives its 16-bit result stream (valid-only; the producer cannot be stalled).
- Buffers one Out_Dim x Out_Dim output frame per bank in a ping-pong register buffer.
- Requantizes each result to 8 bits (round, shift, saturate).
- Re-streams each completed frame to the next stage over a valid/ready handshake, flagging the last pixel of every frame.

Parameters:
- Out_Dim, 2, output feature-map width/height; frame size N = Out_Dim*Out_Dim (N >= 2).
- Shift, 4, right-shift applied during requantization (0..15).
- Idx_W, 8, width of internal index counters; must satisfy N <= 2^Idx_W.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_result  input  16  unsigned convolution result.
- in_valid  input  1  in_result valid this cycle; no backpressure path.
- out_pixel  output  8  requantized pixel.
- out_valid  output  1  out_pixel valid.
- out_ready  input  1  downstream accepts out_pixel.
- out_last  output  1  the current beat is the final pixel of a frame.
- overflow  output  1  sticky: a result was dropped because both banks were full.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst). While rst=0:
  - out_valid=0, out_last=0, overflow=0.
  - Both bank-full flags cleared; wr_bank=0, wr_idx=0, rd_bank=0, rd_idx=0.
  - Buffer contents are not reset; they are don't-care.
- Storage: mem[2][N] x 16 bits.
- Write side (every rising edge, in_valid=1):
  - If full[wr_bank]=0: mem[wr_bank][wr_idx] <= in_result.
    - If wr_idx = N-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
    - Otherwise wr_idx increments.
  - If full[wr_bank]=1: the result is dropped, overflow <= 1, and write pointers are unchanged.
- Read side:
  - out_valid = full[rd_bank]; out_pixel = requant(mem[rd_bank][rd_idx]).
  - out_last = out_valid and (rd_idx = N-1).
  - All three are derived from registers only, with no combinational path from inputs.
  - A transfer occurs on an edge where out_valid and out_ready are both 1: rd_idx increments.
  - On the transfer with rd_idx = N-1: full[rd_bank] <= 0, rd_bank toggles, rd_idx <= 0.
  - out_pixel must stay stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises in the cycle after the edge that writes the Nth result of a frame, provided that bank is the current rd_bank.
- Frame order: frames are emitted strictly in arrival order; pixels are emitted in arrival order within a frame.
- Requantization:
  - Compute t = in_result + (Shift>0 ? 2^(Shift-1) : 0) in 17 bits.
  - q = t >> Shift; out_pixel = (q > 255) ? 255 : q[7:0].
- Simultaneous events:
  - A write setting full on one bank and a read clearing full on the other bank in the same edge are both honored.
  - A write and a read can never hit the same bank's full flag in the same edge.
  - A write into the bank just freed takes effect from the following edge; the freed state is the registered value.
- Overflow clear: ovf_clr=1 clears overflow at the next edge. If a drop occurs on the same edge, the set wins and overflow stays 1.
- Reset mid-operation: partially written or partially read frames are discarded, and out_valid drops immediately (asynchronously). After reset deassertion, the next result begins a new frame in bank 0.
- Continuous input with out_ready held at 1 never overflows, because a frame drains in N cycles while the next one fills.

Test Plan:
- Reset: drive rst=0 with in_valid=1 -> out_valid=0, out_last=0, overflow=0 throughout; no buffer writes occur.
- Single frame (Out_Dim=2, Shift=4, out_ready=1): in_result 0x0010, 0x0018, 0x0FF0, 0x0000 on 4 consecutive cycles -> out_valid high from the next cycle; out_pixel 0x01, 0x02, 0xFF, 0x00; out_last only on the 4th beat; then out_valid=0.
- Backpressure/overflow: out_ready=0, feed 12 results (values 1..12 << 4) -> overflow=1 after the 9th result, and results 9..12 are dropped. Then set out_ready=1 -> exactly 8 pixels 0x01..0x08 appear, with out_last on the 4th and 8th. Pulse ovf_clr -> overflow=0.
- Ping-pong throughput: out_ready=1, 12 back-to-back results -> overflow stays 0; 12 pixels out in order; out_last every 4th beat.
- Stall mid-frame: drop out_ready for 3 cycles on beat 2 -> out_pixel and out_last hold; no duplicate or skipped pixels.
- Reset mid-frame: write 2 results, pulse rst low, then write 4 new results -> only the 4 new pixels are emitted.
- Saturation/rounding: 0xFFFF -> 0xFF. 0x0017 -> 0x01. 0x0018 -> 0x02. With Shift=0: 0x0100 -> 0xFF and 0x00FE -> 0xFE.

Source files
------------

// File: rtl/conv_result_collector.sv
// Ping-pong frame buffer behind the convolution stream: collects Out_Dim x Out_Dim results per
// bank, requantizes them to 8 bits and re-streams each complete frame over valid/ready.
module conv_result_collector #(
  parameter int unsigned Out_Dim = 2,
  parameter int unsigned Shift   = 4,
  parameter int unsigned Idx_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_result,
  input  logic        in_valid,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int unsigned N  = Out_Dim * Out_Dim;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [Idx_W-1:0] LastIdx = Idx_W'(N - 1);
  localparam logic [16:0] Round = (Shift > 0) ? (17'd1 << (Shift - 1)) : 17'd0;

  logic [15:0]      mem_q [2][N];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [Idx_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [Idx_W-1:0] rd_idx_q, rd_idx_d;
  logic             ovf_q, ovf_d;

  logic        wr_en;
  logic        drop;
  logic        xfer;
  logic [15:0] rd_word;
  logic [16:0] rnd_sum;
  logic [16:0] quot;

  // A write only targets a free bank and a read only a full one, so they never share a flag.
  assign wr_en = in_valid && !full_q[wr_bank_q];
  assign drop  = in_valid && full_q[wr_bank_q];
  assign xfer  = full_q[rd_bank_q] && out_ready;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    ovf_d     = ovf_q;

    if (wr_en) begin
      if (wr_idx_q == LastIdx) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + Idx_W'(1);
      end
    end

    if (xfer) begin
      if (rd_idx_q == LastIdx) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + Idx_W'(1);
      end
    end

    // A drop on the same edge as a clear leaves overflow set.
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      ovf_q     <= ovf_d;
    end
  end

  // Buffer contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_idx_q[AW-1:0]] <= in_result;
    end
  end

  always_comb begin
    rd_word = mem_q[rd_bank_q][rd_idx_q[AW-1:0]];
    rnd_sum = {1'b0, rd_word} + Round;
    quot    = rnd_sum >> Shift;
  end

  assign out_pixel = (quot > 17'd255) ? 8'hFF : quot[7:0];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = full_q[rd_bank_q] && (rd_idx_q == LastIdx);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Scoreboard bench: two collectors (Shift=4 and Shift=0) share one stimulus stream and are
// checked against a frame-level reference model.
module tb_conv_result_collector;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic [15:0] in_result;
  logic        in_valid;
  logic        out_ready;
  logic        ovf_clr;

  logic [7:0] pix4, pix0;
  logic       val4, val0, last4, last0, ovf4, ovf0;

  conv_result_collector #(.Out_Dim(2), .Shift(4), .Idx_W(8)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_result (in_result),
    .in_valid  (in_valid),
    .out_pixel (pix4),
    .out_valid (val4),
    .out_ready (out_ready),
    .out_last  (last4),
    .overflow  (ovf4),
    .ovf_clr   (ovf_clr)
  );

  conv_result_collector #(.Out_Dim(2), .Shift(0), .Idx_W(8)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_result (in_result),
    .in_valid  (in_valid),
    .out_pixel (pix0),
    .out_valid (val0),
    .out_ready (out_ready),
    .out_last  (last0),
    .overflow  (ovf0),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: expected beats are {last, pixel}.
  logic [8:0]  exp4_q[$];
  logic [8:0]  exp0_q[$];
  logic [15:0] part_q[$];
  int          pending = 0;
  int          drained = 0;
  bit          m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] requant(input logic [15:0] x, input int sh);
    int t;
    int q;
    t = int'(x) + ((sh > 0) ? (1 << (sh - 1)) : 0);
    q = t / (1 << sh);
    return (q > 255) ? 8'hFF : q[7:0];
  endfunction

  // Model: a bank accepts data unless both banks hold undrained frames.
  initial begin
    bit drop;
    bit xfer;
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp4_q.delete();
        exp0_q.delete();
        part_q.delete();
        pending = 0;
        drained = 0;
        m_ovf   = 1'b0;
      end else begin
        drop = in_valid && (pending == 2);
        xfer = (pending > 0) && out_ready;
        if (in_valid && !drop) begin
          part_q.push_back(in_result);
          if (part_q.size() == N) begin
            for (int i = 0; i < N; i++) begin
              exp4_q.push_back({(i == N - 1), requant(part_q[i], 4)});
              exp0_q.push_back({(i == N - 1), requant(part_q[i], 0)});
            end
            part_q.delete();
            pending++;
          end
        end
        if (xfer) begin
          drained++;
          if (drained == N) begin
            drained = 0;
            pending--;
          end
        end
        if (ovf_clr) m_ovf = 1'b0;
        if (drop)    m_ovf = 1'b1;
      end
    end
  end

  // Monitor: compares presented beats with the queue head; pops on transfer.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_valid4", {31'd0, val4}, 32'd0);
        chk("rst_last4", {31'd0, last4}, 32'd0);
        chk("rst_ovf4", {31'd0, ovf4}, 32'd0);
        chk("rst_valid0", {31'd0, val0}, 32'd0);
      end else begin
        chk("ovf4", {31'd0, ovf4}, {31'd0, m_ovf});
        chk("ovf0", {31'd0, ovf0}, {31'd0, m_ovf});
        chk("valid4", {31'd0, val4}, {31'd0, pending > 0});
        chk("valid0", {31'd0, val0}, {31'd0, pending > 0});
        if (val4) begin
          if (exp4_q.size() == 0) chk("beat4_unexpected", 32'd1, 32'd0);
          else begin
            e = exp4_q[0];
            chk("beat4", {23'd0, last4, pix4}, {23'd0, e});
            if (out_ready) void'(exp4_q.pop_front());
          end
        end else chk("idle_last4", {31'd0, last4}, 32'd0);
        if (val0) begin
          if (exp0_q.size() == 0) chk("beat0_unexpected", 32'd1, 32'd0);
          else begin
            e = exp0_q[0];
            chk("beat0", {23'd0, last0, pix0}, {23'd0, e});
            if (out_ready) void'(exp0_q.pop_front());
          end
        end else chk("idle_last0", {31'd0, last0}, 32'd0);
      end
    end
  end

  task automatic step(input bit v, input logic [15:0] d, input bit rdy, input bit clr);
    in_valid  = v;
    in_result = d;
    out_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] sat_vals [8];
    sat_vals = '{16'hFFFF, 16'h0017, 16'h0018, 16'h0100, 16'h00FE, 16'h0008, 16'h0007, 16'h1234};

    // Reset held with live input: nothing may be captured.
    rst = 1'b0;
    in_valid = 1'b1;
    in_result = 16'h0123;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) step(0, 16'h0, 1, 0);

    // Single frame.
    step(1, 16'h0010, 1, 0);
    step(1, 16'h0018, 1, 0);
    step(1, 16'h0FF0, 1, 0);
    step(1, 16'h0000, 1, 0);
    repeat (6) step(0, 16'h0, 1, 0);

    // Backpressure until both banks fill, then drain and clear overflow.
    for (int i = 1; i <= 12; i++) step(1, 16'(i << 4), 0, 0);
    repeat (3) step(0, 16'h0, 0, 0);
    repeat (12) step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 1);
    repeat (2) step(0, 16'h0, 1, 0);

    // Ping-pong throughput.
    for (int i = 0; i < 12; i++) step(1, 16'($urandom), 1, 0);
    repeat (6) step(0, 16'h0, 1, 0);

    // Stall mid-frame.
    for (int i = 0; i < 4; i++) step(1, 16'($urandom), 1, 0);
    step(0, 16'h0, 1, 0);
    repeat (3) step(0, 16'h0, 0, 0);
    repeat (6) step(0, 16'h0, 1, 0);

    // Reset mid-operation with a full bank presenting: out_valid must drop at once.
    for (int i = 0; i < 6; i++) step(1, 16'($urandom), 0, 0);
    rst = 1'b0;
    #1;
    chk("async_drop4", {31'd0, val4}, 32'd0);
    chk("async_drop0", {31'd0, val0}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 16'($urandom), 1, 0);
    repeat (6) step(0, 16'h0, 1, 0);

    // Rounding and saturation corners.
    for (int i = 0; i < 8; i++) step(1, sat_vals[i], 1, 0);
    repeat (6) step(0, 16'h0, 1, 0);

    // Random traffic with overflow pressure and sporadic clears.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 19) == 0));
    end

    repeat (20) step(0, 16'h0, 1, 0);
    chk("drained4", exp4_q.size(), 32'd0);
    chk("drained0", exp0_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
